mini_src_datapath: RTL and testbench



---
 rtl/mini_src_pkg.sv | 30 +++
 rtl/mini_src_if.sv | 41 ++++
 rtl/mini_src_alu.sv | 74 +++++++
 rtl/mini_src_datapath.sv | 87 ++++++++
 tb/tb_mini_src_datapath.sv | 293 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mini_src_pkg.sv
// Shared definitions for the Mini SRC datapath: bus/register sizing, the
// ALU operation codes and the helper that builds the IR constant operand.
package mini_src_pkg;

  localparam int WIDTH = 32;   // data / bus width
  localparam int NREGS = 16;   // general registers R0..R15
  localparam int C_W   = 19;   // width of the IR C field
  localparam int OP_W  = 5;    // alu_control width

  localparam logic [OP_W-1:0] ALU_ADD  = 5'd0;
  localparam logic [OP_W-1:0] ALU_SUB  = 5'd1;
  localparam logic [OP_W-1:0] ALU_AND  = 5'd2;
  localparam logic [OP_W-1:0] ALU_OR   = 5'd3;
  localparam logic [OP_W-1:0] ALU_SHR  = 5'd4;
  localparam logic [OP_W-1:0] ALU_SHRA = 5'd5;
  localparam logic [OP_W-1:0] ALU_SHL  = 5'd6;
  localparam logic [OP_W-1:0] ALU_ROR  = 5'd7;
  localparam logic [OP_W-1:0] ALU_ROL  = 5'd8;
  localparam logic [OP_W-1:0] ALU_MUL  = 5'd9;
  localparam logic [OP_W-1:0] ALU_DIV  = 5'd10;
  localparam logic [OP_W-1:0] ALU_NEG  = 5'd11;
  localparam logic [OP_W-1:0] ALU_NOT  = 5'd12;
  localparam logic [OP_W-1:0] ALU_INC  = 5'd13;

  // Sign-extend the IR C field to a full bus word.
  function automatic logic [WIDTH-1:0] sext_c(input logic [C_W-1:0] c);
    return {{(WIDTH-C_W){c[C_W-1]}}, c};
  endfunction

endpackage

// File: rtl/mini_src_if.sv
// Control/observation bundle between the Mini SRC control unit (master)
// and the datapath (slave).
//   Rout[n] / Ren[n]   : drive Rn onto the bus / load Rn from the bus
//   MDROut..Yout       : remaining one-hot bus out-selects
//   IRen..LOen         : special register load enables
//   Read               : MDR takes Mdatain instead of the bus
//   alu_control        : ALU operation select
//   stop               : halt request
//   run, bus_q, mar_q, mdr_q, ir_q : datapath observation outputs
interface mini_src_if;
  import mini_src_pkg::*;

  logic              stop;
  logic [OP_W-1:0]   alu_control;
  logic [WIDTH-1:0]  Mdatain;
  logic [NREGS-1:0]  Rout;
  logic [NREGS-1:0]  Ren;
  logic              MDROut, HIout, LOout, ZHIout, ZLOout, Pout, Cout, Yout;
  logic              IRen, MARen, MDRen, Yen, Pen, ZHIen, ZLOen, HIen, LOen;
  logic              Read;
  logic              run;
  logic [WIDTH-1:0]  bus_q;
  logic [WIDTH-1:0]  mar_q;
  logic [WIDTH-1:0]  mdr_q;
  logic [WIDTH-1:0]  ir_q;

  modport master (
    output stop, alu_control, Mdatain, Rout, Ren,
    output MDROut, HIout, LOout, ZHIout, ZLOout, Pout, Cout, Yout,
    output IRen, MARen, MDRen, Yen, Pen, ZHIen, ZLOen, HIen, LOen, Read,
    input  run, bus_q, mar_q, mdr_q, ir_q
  );

  modport slave (
    input  stop, alu_control, Mdatain, Rout, Ren,
    input  MDROut, HIout, LOout, ZHIout, ZLOout, Pout, Cout, Yout,
    input  IRen, MARen, MDRen, Yen, Pen, ZHIen, ZLOen, HIen, LOen, Read,
    output run, bus_q, mar_q, mdr_q, ir_q
  );

endinterface

// File: rtl/mini_src_alu.sv
// Combinational Mini SRC ALU.
//   a      : operand A (Y register)
//   b      : operand B (bus)
//   op     : operation code (mini_src_pkg ALU_*)
//   result : 64-bit result, [63:32] -> ZHI, [31:0] -> ZLO
module mini_src_alu
  import mini_src_pkg::*;
(
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [OP_W-1:0]    op,
  output logic [2*WIDTH-1:0] result
);

  localparam int DW = 2 * WIDTH;

  logic signed [DW-1:0]    a_ext;
  logic signed [DW-1:0]    b_ext;
  logic signed [DW-1:0]    div_b;
  logic signed [DW-1:0]    prod;
  logic signed [WIDTH-1:0] quot;
  logic signed [WIDTH-1:0] rem;
  logic [4:0]              shamt;
  logic [WIDTH-1:0]        hi;
  logic [WIDTH-1:0]        lo;

  assign shamt = b[4:0];
  assign a_ext = {{WIDTH{a[WIDTH-1]}}, a};
  assign b_ext = {{WIDTH{b[WIDTH-1]}}, b};
  assign prod  = a_ext * b_ext;

  // Divide in double width so -2^31 / -1 does not trap; the divisor is
  // forced to 1 when B is zero, and that case is overridden below anyway.
  assign div_b = (b == '0) ? DW'(1) : b_ext;
  assign quot  = WIDTH'(a_ext / div_b);
  assign rem   = WIDTH'(a_ext % div_b);

  always_comb begin
    hi = '0;
    lo = '0;
    case (op)
      ALU_ADD:  lo = a + b;
      ALU_SUB:  lo = a - b;
      ALU_AND:  lo = a & b;
      ALU_OR:   lo = a | b;
      ALU_SHR:  lo = a >> shamt;
      ALU_SHRA: lo = $signed(a) >>> shamt;
      ALU_SHL:  lo = a << shamt;
      ALU_ROR:  lo = WIDTH'({a, a} >> shamt);
      // Rotate left by n is rotate right by (32 - n) mod 32.
      ALU_ROL:  lo = WIDTH'({a, a} >> (5'd0 - shamt));
      ALU_MUL: begin
        hi = prod[DW-1:WIDTH];
        lo = prod[WIDTH-1:0];
      end
      ALU_DIV: begin
        if (b == '0) begin
          hi = a;
          lo = '1;
        end else begin
          hi = rem;
          lo = quot;
        end
      end
      ALU_NEG:  lo = '0 - b;
      ALU_NOT:  lo = ~b;
      ALU_INC:  lo = b + WIDTH'(1);
      default: ;
    endcase
  end

  assign result = {hi, lo};

endmodule

// File: rtl/mini_src_datapath.sv
// Mini SRC single-bus datapath: R0..R15, HI, LO, PC, IR, MAR, MDR, Y and
// the 64-bit Z register (ZHI/ZLO) around a combinational ALU.
//   clk : rising-edge clock for every register
//   clr : asynchronous active-high reset (all registers 0, run = 1)
//   io  : mini_src_if.slave -- out-selects, load enables, Read, stop,
//         alu_control, Mdatain in; run, bus_q, mar_q, mdr_q, ir_q out
module mini_src_datapath
  import mini_src_pkg::*;
(
  input  logic      clk,
  input  logic      clr,
  mini_src_if.slave io
);

  logic [WIDTH-1:0]   gpr [NREGS];
  logic [WIDTH-1:0]   hi, lo, pc, ir, mar, mdr, y, zhi, zlo;
  logic               run;
  logic [WIDTH-1:0]   bus;
  logic [2*WIDTH-1:0] alu_result;
  logic               ld;

  // Bus mux: walk from lowest to highest priority so the highest-priority
  // asserted select is the last assignment and wins.
  always_comb begin
    bus = '0;
    if (io.Yout)   bus = y;
    if (io.Cout)   bus = sext_c(ir[C_W-1:0]);
    if (io.Pout)   bus = pc;
    if (io.ZLOout) bus = zlo;
    if (io.ZHIout) bus = zhi;
    if (io.LOout)  bus = lo;
    if (io.HIout)  bus = hi;
    if (io.MDROut) bus = mdr;
    for (int i = NREGS - 1; i >= 0; i--) begin
      if (io.Rout[i]) bus = gpr[i];
    end
  end

  mini_src_alu u_alu (
    .a      (y),
    .b      (bus),
    .op     (io.alu_control),
    .result (alu_result)
  );

  // A stop on the edge that halts the datapath also suppresses that edge's loads.
  assign ld = run & ~io.stop;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      run <= 1'b1;
      for (int i = 0; i < NREGS; i++) gpr[i] <= '0;
      hi  <= '0;
      lo  <= '0;
      pc  <= '0;
      ir  <= '0;
      mar <= '0;
      mdr <= '0;
      y   <= '0;
      zhi <= '0;
      zlo <= '0;
    end else begin
      if (io.stop) run <= 1'b0;
      if (ld) begin
        for (int i = 0; i < NREGS; i++) begin
          if (io.Ren[i]) gpr[i] <= bus;
        end
        if (io.HIen)  hi  <= bus;
        if (io.LOen)  lo  <= bus;
        if (io.Pen)   pc  <= bus;
        if (io.IRen)  ir  <= bus;
        if (io.MARen) mar <= bus;
        if (io.MDRen) mdr <= io.Read ? io.Mdatain : bus;
        if (io.Yen)   y   <= bus;
        if (io.ZHIen) zhi <= alu_result[2*WIDTH-1:WIDTH];
        if (io.ZLOen) zlo <= alu_result[WIDTH-1:0];
      end
    end
  end

  assign io.run   = run;
  assign io.bus_q = bus;
  assign io.mar_q = mar;
  assign io.mdr_q = mdr;
  assign io.ir_q  = ir;

endmodule

// File: tb/tb_mini_src_datapath.sv
// Self-checking bench for mini_src_datapath: directed sequences, a table of
// ALU vectors and randomized ALU/register traffic against a reference model.
module tb_mini_src_datapath;
  import mini_src_pkg::*;

  logic clk = 1'b0;
  logic clr;
  always #5 clk = ~clk;

  mini_src_if dif ();

  mini_src_datapath dut (
    .clk (clk),
    .clr (clr),
    .io  (dif.slave)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [4:0]  op;
    logic [31:0] y;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  vec_t vecs [19];
  logic [31:0] gm [16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference ALU computed from the operation definitions with 64-bit integers.
  function automatic logic [63:0] ref_alu(input logic [4:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
    longint sa, sb, ua, ub, q, r;
    int n;
    logic [31:0] lo;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'd0, a};
    ub = {32'd0, b};
    n  = int'(b[4:0]);
    lo = '0;
    case (op)
      5'd0:  lo = 32'(ua + ub);
      5'd1:  lo = 32'(ua - ub);
      5'd2:  lo = a & b;
      5'd3:  lo = a | b;
      5'd4:  lo = 32'(ua / (64'sd1 << n));
      5'd5:  lo = 32'(sa >>> n);
      5'd6:  lo = 32'(ua * (64'sd1 << n));
      5'd7:  lo = 32'((ua >> n) | (ua << (32 - n)));
      5'd8:  lo = 32'((ua << n) | (ua >> (32 - n)));
      5'd9:  return 64'(sa * sb);
      5'd10: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        q = sa / sb;
        r = sa - q * sb;
        return {32'(r), 32'(q)};
      end
      5'd11: lo = 32'(64'sd0 - ub);
      5'd12: lo = ~b;
      5'd13: lo = 32'(ub + 64'sd1);
      default: lo = '0;
    endcase
    return {32'd0, lo};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    dif.stop = 1'b0; dif.alu_control = '0; dif.Mdatain = '0;
    dif.Rout = '0; dif.Ren = '0;
    dif.MDROut = 0; dif.HIout = 0; dif.LOout = 0; dif.ZHIout = 0;
    dif.ZLOout = 0; dif.Pout = 0; dif.Cout = 0; dif.Yout = 0;
    dif.IRen = 0; dif.MARen = 0; dif.MDRen = 0; dif.Yen = 0; dif.Pen = 0;
    dif.ZHIen = 0; dif.ZLOen = 0; dif.HIen = 0; dif.LOen = 0; dif.Read = 0;
  endtask

  task automatic load_mdr(input logic [31:0] v);
    idle();
    dif.Mdatain = v; dif.Read = 1; dif.MDRen = 1;
    tick();
    idle();
  endtask

  task automatic write_reg(input int n, input logic [31:0] v);
    load_mdr(v);
    dif.MDROut = 1; dif.Ren[n] = 1;
    tick();
    idle();
  endtask

  task automatic read_reg(input int n, output logic [31:0] v);
    idle();
    dif.Rout[n] = 1;
    #1;
    v = dif.bus_q;
    idle();
  endtask

  task automatic alu_op(input logic [4:0] op, input logic [31:0] yv, input logic [31:0] bv,
                        output logic [31:0] hi_o, output logic [31:0] lo_o);
    load_mdr(yv);
    dif.MDROut = 1; dif.Yen = 1;
    tick();
    load_mdr(bv);
    dif.MDROut = 1; dif.alu_control = op; dif.ZHIen = 1; dif.ZLOen = 1;
    tick();
    idle();
    dif.ZHIout = 1; #1; hi_o = dif.bus_q;
    idle();
    dif.ZLOout = 1; #1; lo_o = dif.bus_q;
    idle();
  endtask

  initial begin
    logic [31:0] hv, lv, rv;
    logic [63:0] ev;
    logic [4:0]  op;
    logic [31:0] yv, bv;
    int n, m;

    vecs[0]  = '{ALU_MUL,  32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB};
    vecs[1]  = '{ALU_DIV,  32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[2]  = '{ALU_DIV,  32'd7,        32'd0,        32'd7,        32'hFFFFFFFF};
    vecs[3]  = '{ALU_SHRA, 32'h80000001, 32'd1,        32'd0,        32'hC0000000};
    vecs[4]  = '{ALU_SHR,  32'h80000001, 32'd1,        32'd0,        32'h40000000};
    vecs[5]  = '{ALU_ROR,  32'h80000001, 32'd1,        32'd0,        32'hC0000000};
    vecs[6]  = '{ALU_ROL,  32'h80000001, 32'd1,        32'd0,        32'h00000003};
    vecs[7]  = '{ALU_ADD,  32'hFFFFFFFF, 32'd1,        32'd0,        32'd0};
    vecs[8]  = '{ALU_SUB,  32'd0,        32'd1,        32'd0,        32'hFFFFFFFF};
    vecs[9]  = '{ALU_AND,  32'h0000F0F0, 32'h0000FF00, 32'd0,        32'h0000F000};
    vecs[10] = '{ALU_OR,   32'h0000F0F0, 32'h0000FF00, 32'd0,        32'h0000FFF0};
    vecs[11] = '{ALU_SHL,  32'd3,        32'd33,       32'd0,        32'd6};
    vecs[12] = '{ALU_NEG,  32'h00012345, 32'd5,        32'd0,        32'hFFFFFFFB};
    vecs[13] = '{ALU_NOT,  32'd0,        32'd0,        32'd0,        32'hFFFFFFFF};
    vecs[14] = '{ALU_INC,  32'd0,        32'hFFFFFFFF, 32'd0,        32'd0};
    vecs[15] = '{5'd14,    32'd5,        32'd6,        32'd0,        32'd0};
    vecs[16] = '{ALU_DIV,  32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD};
    vecs[17] = '{ALU_MUL,  32'h80000000, 32'h80000000, 32'h40000000, 32'd0};
    vecs[18] = '{ALU_ROR,  32'h12345678, 32'd0,        32'd0,        32'h12345678};

    // Reset
    idle();
    clr = 1'b1;
    tick();
    tick();
    check("reset_run", {31'd0, dif.run}, 32'd1);
    check("reset_mar", dif.mar_q, 32'd0);
    check("reset_mdr", dif.mdr_q, 32'd0);
    check("reset_ir", dif.ir_q, 32'd0);
    clr = 1'b0;
    tick();
    for (int i = 0; i < 16; i++) begin
      read_reg(i, rv);
      check($sformatf("reset_R%0d", i), rv, 32'd0);
      gm[i] = 32'd0;
    end
    dif.HIout = 1;  #1; check("reset_hi",  dif.bus_q, 32'd0); idle();
    dif.LOout = 1;  #1; check("reset_lo",  dif.bus_q, 32'd0); idle();
    dif.ZHIout = 1; #1; check("reset_zhi", dif.bus_q, 32'd0); idle();
    dif.ZLOout = 1; #1; check("reset_zlo", dif.bus_q, 32'd0); idle();
    dif.Pout = 1;   #1; check("reset_pc",  dif.bus_q, 32'd0); idle();
    dif.Yout = 1;   #1; check("reset_y",   dif.bus_q, 32'd0); idle();
    #1; check("no_select_bus", dif.bus_q, 32'd0);

    // Load and readback through MDR into R2
    load_mdr(32'h12);
    check("mdr_load", dif.mdr_q, 32'h12);
    dif.MDROut = 1; dif.Ren[2] = 1;
    tick();
    read_reg(2, rv);
    check("r2_readback", rv, 32'h12);

    // ADD sequence: R4 = R3 + R7
    write_reg(3, 32'd5);
    write_reg(7, 32'd6);
    dif.Rout[3] = 1; dif.Yen = 1; tick(); idle();
    dif.Rout[7] = 1; dif.alu_control = ALU_ADD; dif.ZLOen = 1; tick(); idle();
    dif.ZLOout = 1; dif.Ren[4] = 1; tick(); idle();
    read_reg(4, rv);
    check("add_r4", rv, 32'd11);

    // ALU vector table
    for (int i = 0; i < 19; i++) begin
      alu_op(vecs[i].op, vecs[i].y, vecs[i].b, hv, lv);
      check($sformatf("vec%0d_op%0d_zhi", i, vecs[i].op), hv, vecs[i].hi);
      check($sformatf("vec%0d_op%0d_zlo", i, vecs[i].op), lv, vecs[i].lo);
    end

    // IR constant, MAR, and bus priority
    load_mdr(32'h0007FFFF);
    dif.MDROut = 1; dif.IRen = 1; dif.MARen = 1; tick(); idle();
    check("ir_load", dif.ir_q, 32'h0007FFFF);
    check("mar_load", dif.mar_q, 32'h0007FFFF);
    dif.Cout = 1; #1; check("cout_sext_neg", dif.bus_q, 32'hFFFFFFFF); idle();
    load_mdr(32'h0003FFFF);
    dif.MDROut = 1; dif.IRen = 1; tick(); idle();
    dif.Cout = 1; #1; check("cout_sext_pos", dif.bus_q, 32'h0003FFFF); idle();
    write_reg(1, 32'h0000AAAA);
    load_mdr(32'h0000BBBB);
    dif.MDROut = 1; dif.Pen = 1; tick(); idle();
    dif.Rout[1] = 1; dif.Pout = 1; #1; check("prio_r1_over_pc", dif.bus_q, 32'h0000AAAA); idle();
    dif.Pout = 1; #1; check("pc_alone", dif.bus_q, 32'h0000BBBB); idle();
    write_reg(0, 32'd1);
    write_reg(15, 32'd2);
    dif.Rout[15] = 1; dif.Rout[0] = 1; #1; check("prio_r0_over_r15", dif.bus_q, 32'd1); idle();
    dif.Yout = 1; dif.Cout = 1; #1; check("prio_c_over_y", dif.bus_q, 32'h0003FFFF); idle();
    #1; check("no_select_bus2", dif.bus_q, 32'd0);
    gm[0] = 32'd1; gm[1] = 32'h0000AAAA; gm[2] = 32'h12; gm[3] = 32'd5;
    gm[4] = 32'd11; gm[7] = 32'd6; gm[15] = 32'd2;

    // Read-before-write: ZLO <= ZLO + 1 in one cycle
    alu_op(ALU_ADD, 32'd0, 32'h10, hv, lv);
    dif.ZLOout = 1; dif.ZLOen = 1; dif.alu_control = ALU_INC; tick(); idle();
    dif.ZLOout = 1; #1; check("zlo_read_before_write", dif.bus_q, 32'h11); idle();

    // Randomized ALU operations against the reference model
    for (int i = 0; i < 60; i++) begin
      op = 5'($urandom_range(0, 15));
      yv = $urandom;
      bv = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      alu_op(op, yv, bv, hv, lv);
      ev = ref_alu(op, yv, bv);
      check($sformatf("rand_op%0d_%h_%h_zhi", op, yv, bv), hv, ev[63:32]);
      check($sformatf("rand_op%0d_%h_%h_zlo", op, yv, bv), lv, ev[31:0]);
    end

    // Randomized register writes and register-to-register copies
    for (int i = 0; i < 30; i++) begin
      n = $urandom_range(0, 15);
      if ($urandom_range(0, 1) == 0) begin
        yv = $urandom;
        write_reg(n, yv);
        gm[n] = yv;
      end else begin
        m = $urandom_range(0, 15);
        dif.Rout[m] = 1; dif.Ren[n] = 1; tick(); idle();
        gm[n] = gm[m];
      end
    end
    for (int i = 0; i < 16; i++) begin
      read_reg(i, rv);
      check($sformatf("scoreboard_R%0d", i), rv, gm[i]);
    end

    // Stop: the halting edge performs no loads, later enables are ignored
    write_reg(5, 32'd1);
    load_mdr(32'd9);
    dif.MDROut = 1; dif.Ren[5] = 1; dif.stop = 1; tick(); idle();
    check("stop_run_low", {31'd0, dif.run}, 32'd0);
    read_reg(5, rv);
    check("stop_r5_held", rv, 32'd1);
    dif.MDROut = 1; dif.Ren[5] = 1; tick(); idle();
    read_reg(5, rv);
    check("halted_r5_held", rv, 32'd1);
    dif.Mdatain = 32'd77; dif.Read = 1; dif.MDRen = 1; tick(); idle();
    check("halted_mdr_held", dif.mdr_q, 32'd9);
    check("halted_run_low", {31'd0, dif.run}, 32'd0);
    dif.MDROut = 1; #1; check("halted_bus_live", dif.bus_q, 32'd9); idle();

    // Asynchronous clear between edges
    @(posedge clk);
    #3;
    clr = 1'b1;
    #1;
    check("clr_run", {31'd0, dif.run}, 32'd1);
    check("clr_mdr", dif.mdr_q, 32'd0);
    check("clr_ir", dif.ir_q, 32'd0);
    check("clr_mar", dif.mar_q, 32'd0);
    dif.Rout[5] = 1; #1; check("clr_r5", dif.bus_q, 32'd0); idle();
    clr = 1'b0;
    write_reg(6, 32'h00C0FFEE);
    read_reg(6, rv);
    check("after_clr_load", rv, 32'h00C0FFEE);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
